// File: rtl/binary_gcd.sv
// -----------------------------------------------------------------------------
// binary_gcd
//
// Sequential Stein (binary) GCD engine for unsigned WIDTH-bit operands.
// Factors of two are stripped from the operands with trailing-zero counts.
// The odd parts are then reduced by subtract-and-strip steps, one per cycle.
// The common power of two is shifted back into the result at the end.
// Only one operation is in flight at a time.
//
// Ports
//   clock_i   in   1      rising-edge clock
//   reset_ni  in   1      asynchronous active-low reset
//   valid_i   in   1      request valid
//   ready_o   out  1      engine idle, request accepted on valid_i & ready_o
//   a_i       in   WIDTH  operand A, sampled on acceptance
//   b_i       in   WIDTH  operand B, sampled on acceptance
//   valid_o   out  1      result valid (held until ready_i)
//   ready_i   in   1      consumer accepts the result
//   gcd_o     out  WIDTH  gcd(A, B); gcd(0,0)=0, gcd(x,0)=x
// -----------------------------------------------------------------------------

// Combinational trailing-zero counter. An all-zero input returns WIDTH.
module binary_gcd_tz #(
   parameter int WIDTH = 32,
   parameter int TZW   = $clog2(WIDTH) + 1
) (
   input  logic [WIDTH-1:0] value,
   output logic [TZW-1:0]   count
);
   always_comb begin
      count = TZW'(WIDTH);
      // Scanning downwards lets the lowest set bit win.
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (value[i]) count = TZW'(i);
      end
   end
endmodule

module binary_gcd #(
   parameter int WIDTH = 32
) (
   input  logic             clock_i,
   input  logic             reset_ni,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] gcd_o
);
   localparam int TZW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STRIP  = 2'd1,
      S_REDUCE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] ra_reg, rb_reg, gcd_reg;
   logic [TZW-1:0]   k_reg;

   logic             ra_lt_rb, any_zero, equal;
   logic [WIDTH-1:0] diff, min_ab;
   logic [TZW-1:0]   k_strip;
   logic [WIDTH-1:0] tz_in  [2];
   logic [TZW-1:0]   tz_cnt [2];

   // Two counters cover every cycle.
   // In STRIP they count tz(ra) and tz(rb), and tz(ra|rb) is their minimum.
   // In REDUCE unit 0 is switched over to count the difference.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_tz
         binary_gcd_tz #(.WIDTH(WIDTH), .TZW(TZW)) u_tz (
            .value(tz_in[gi]),
            .count(tz_cnt[gi])
         );
      end
   endgenerate

   always_comb begin
      ra_lt_rb = (ra_reg < rb_reg);
      equal    = (ra_reg == rb_reg);
      any_zero = (ra_reg == '0) || (rb_reg == '0);
      diff     = ra_lt_rb ? (rb_reg - ra_reg) : (ra_reg - rb_reg);
      min_ab   = ra_lt_rb ? ra_reg : rb_reg;
      tz_in[0] = (state_reg == S_STRIP) ? ra_reg : diff;
      tz_in[1] = rb_reg;
      k_strip  = (tz_cnt[0] < tz_cnt[1]) ? tz_cnt[0] : tz_cnt[1];
   end

   // State register
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) state_reg <= S_IDLE;
      else           state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (valid_i) state_next = S_STRIP;
         S_STRIP:  state_next = any_zero ? S_DONE : S_REDUCE;
         S_REDUCE: if (equal) state_next = S_DONE;
         S_DONE:   if (ready_i) state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Outputs are plain decodes of the registered state.
   always_comb begin
      ready_o = (state_reg == S_IDLE);
      valid_o = (state_reg == S_DONE);
      gcd_o   = gcd_reg;
   end

   // Datapath registers
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         ra_reg  <= '0;
         rb_reg  <= '0;
         k_reg   <= '0;
         gcd_reg <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (valid_i) begin
                  ra_reg <= a_i;
                  rb_reg <= b_i;
               end
            end
            S_STRIP: begin
               if (any_zero) begin
                  gcd_reg <= ra_reg | rb_reg;
               end else begin
                  k_reg  <= k_strip;
                  ra_reg <= ra_reg >> tz_cnt[0];
                  rb_reg <= rb_reg >> tz_cnt[1];
               end
            end
            S_REDUCE: begin
               if (equal) begin
                  // The result divides both operands, so this shift cannot overflow.
                  gcd_reg <= ra_reg << k_reg;
               end else begin
                  // Both operands are odd, so diff is even and nonzero.
                  ra_reg <= min_ab;
                  rb_reg <= diff >> tz_cnt[0];
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_binary_gcd.sv
module tb_binary_gcd;
   localparam int WIDTH   = 32;
   localparam int MAX_LAT = 2 * WIDTH + 1;

   logic             clock_i  = 1'b0;
   logic             reset_ni = 1'b0;
   logic             valid_i  = 1'b0;
   logic             ready_i  = 1'b0;
   logic [WIDTH-1:0] a_i      = '0;
   logic [WIDTH-1:0] b_i      = '0;
   logic             ready_o;
   logic             valid_o;
   logic [WIDTH-1:0] gcd_o;

   binary_gcd #(.WIDTH(WIDTH)) dut (
      .clock_i (clock_i),
      .reset_ni(reset_ni),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .a_i     (a_i),
      .b_i     (b_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .gcd_o   (gcd_o)
   );

   always #5 clock_i = ~clock_i;

   int tests   = 0;
   int fails   = 0;
   int accepts = 0;
   int results = 0;
   int aborted = 0;

   // Handshake monitor.
   always @(posedge clock_i) begin
      if (reset_ni && valid_i && ready_o) accepts <= accepts + 1;
      if (reset_ni && valid_o && ready_i) results <= results + 1;
   end

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] exp;
      int               lat;
   } vec_t;

   vec_t vecs [9];

   // Reference: Euclid's algorithm with the remainder operator.
   function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   // One full transaction.
   // exp_lat < 0 means the latency is checked only against its bounds.
   // stall == 0 means ready_i is already high before the result arrives.
   // With pulse set, a new request is offered during the stall and must be ignored.
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp, input int exp_lat,
                         input int stall, input bit pulse);
      int budget;
      int lat;
      bit held;
      budget = 0;
      @(negedge clock_i);
      while (!ready_o && budget < 4 * MAX_LAT) begin
         @(negedge clock_i);
         budget++;
      end
      if (!ready_o) begin
         check("ready_timeout", {31'b0, ready_o}, 1);
         return;
      end
      a_i     = a;
      b_i     = b;
      valid_i = 1'b1;
      ready_i = (stall == 0);
      @(posedge clock_i);
      #1 valid_i = 1'b0;
      lat = 0;
      while (lat < MAX_LAT + 10) begin
         @(posedge clock_i);
         #1 lat++;
         if (valid_o) break;
      end
      check("result_timeout", {31'b0, valid_o}, 1);
      if (!valid_o) return;
      check("gcd", gcd_o, exp);
      if (exp_lat >= 0) begin
         check("latency", lat, exp_lat);
      end else begin
         check("latency_bound", {31'b0, (lat >= 2 && lat <= MAX_LAT)}, 1);
      end
      held = 1'b1;
      for (int i = 0; i < stall; i++) begin
         @(negedge clock_i);
         if (pulse && i == 1) begin
            valid_i = 1'b1;
            a_i     = 100;
            b_i     = 75;
         end else begin
            valid_i = 1'b0;
         end
         @(posedge clock_i);
         #1;
         if (valid_o !== 1'b1 || gcd_o !== exp || ready_o !== 1'b0) held = 1'b0;
      end
      if (stall > 0) begin
         check("hold_in_done", {31'b0, held}, 1);
         @(negedge clock_i);
         valid_i = 1'b0;
         ready_i = 1'b1;
      end
      @(posedge clock_i);
      #1 check("done_to_idle", {30'b0, ready_o, valid_o}, 2'b10);
      @(negedge clock_i);
      ready_i = 1'b0;
      $display("[TB] gcd(%0d,%0d) = %0d latency %0d stall %0d", a, b, gcd_o, lat, stall);
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      int sel, sh, el;

      vecs[0] = '{a: 32'd12,         b: 32'd18,         exp: 32'd6,          lat: 3};
      vecs[1] = '{a: 32'd0,          b: 32'd7,          exp: 32'd7,          lat: 1};
      vecs[2] = '{a: 32'd5,          b: 32'd0,          exp: 32'd5,          lat: 1};
      vecs[3] = '{a: 32'd0,          b: 32'd0,          exp: 32'd0,          lat: 1};
      vecs[4] = '{a: 32'h8000_0000,  b: 32'h4000_0000,  exp: 32'h4000_0000,  lat: 2};
      vecs[5] = '{a: 32'd1,          b: 32'd1,          exp: 32'd1,          lat: 2};
      vecs[6] = '{a: 32'd7,          b: 32'd7,          exp: 32'd7,          lat: 2};
      vecs[7] = '{a: 32'd1071,       b: 32'd462,        exp: 32'd21,         lat: 6};
      vecs[8] = '{a: 32'd48,         b: 32'd18,         exp: 32'd6,          lat: 3};

      // Reset state
      repeat (3) @(posedge clock_i);
      #1;
      check("reset_ready", {31'b0, ready_o}, 1);
      check("reset_valid", {31'b0, valid_o}, 0);
      check("reset_gcd", gcd_o, 0);
      @(negedge clock_i);
      reset_ni = 1'b1;

      // Table of directed vectors
      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, i % 3, 1'b0);
      end

      // Backpressure: 5 stalled cycles with a request offered and ignored
      run_op(32'd12, 32'd18, 32'd6, 3, 5, 1'b1);

      // Reset during REDUCE on a long coprime pair
      @(negedge clock_i);
      a_i     = 32'd1836311903;
      b_i     = 32'd1134903170;
      valid_i = 1'b1;
      ready_i = 1'b0;
      @(posedge clock_i);
      #1 valid_i = 1'b0;
      repeat (4) @(posedge clock_i);
      #3;
      check("midop_not_done", {31'b0, valid_o}, 0);
      reset_ni = 1'b0;
      aborted  = 1;
      #1;
      check("abort_ready", {31'b0, ready_o}, 1);
      check("abort_valid", {31'b0, valid_o}, 0);
      check("abort_gcd", gcd_o, 0);
      repeat (2) @(negedge clock_i);
      reset_ni = 1'b1;
      run_op(32'd48, 32'd18, 32'd6, 3, 1, 1'b0);

      // Random pairs against the reference
      for (int n = 0; n < 1000; n++) begin
         sel = $urandom_range(0, 9);
         ra  = $urandom;
         rb  = $urandom;
         if (sel == 0) begin
            case ($urandom_range(0, 2))
               0:       ra = '0;
               1:       rb = '0;
               default: begin ra = '0; rb = '0; end
            endcase
         end else if (sel == 1) begin
            sh = $urandom_range(8, 24);
            ra = ra << sh;
            rb = rb << sh;
         end
         el = (ra == 0 || rb == 0) ? 1 : -1;
         run_op(ra, rb, ref_gcd(ra, rb), el, $urandom_range(0, 3), 1'b0);
      end

      repeat (2) @(posedge clock_i);
      #1 check("one_result_per_accept", results, accepts - aborted);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
